// File: rtl/difftest_commit_queue_if.sv
// ---------------------------------------------------------------------------
// difftest_commit_queue_if
//   Record channel from the commit queue to the difftest bridge.
//
//   Handshake: a record transfers on every clock edge where rec_valid and
//   rec_ready are both high. The producer holds rec_valid and every rec_*
//   field stable until that transfer. rec_valid does not depend on
//   rec_ready. The consumer may raise or drop rec_ready at any time.
//
//   Signals:
//     rec_valid     producer -> consumer  record available
//     rec_ready     consumer -> producer  record accepted this edge
//     rec_skip      reference model must skip this record
//     rec_pc        retired PC
//     rec_ins       retired instruction
//     rec_rd_we     rd written (0 whenever rd_addr == 0)
//     rec_rd_addr   rd index
//     rec_rd_data   rd value
//
//   Modports: master = commit queue (producer), slave = bridge (consumer).
// ---------------------------------------------------------------------------
interface difftest_commit_queue_if;
  logic        rec_valid;
  logic        rec_ready;
  logic        rec_skip;
  logic [63:0] rec_pc;
  logic [31:0] rec_ins;
  logic        rec_rd_we;
  logic [4:0]  rec_rd_addr;
  logic [63:0] rec_rd_data;

  modport master (
    output rec_valid,
    output rec_skip,
    output rec_pc,
    output rec_ins,
    output rec_rd_we,
    output rec_rd_addr,
    output rec_rd_data,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_skip,
    input  rec_pc,
    input  rec_ins,
    input  rec_rd_we,
    input  rec_rd_addr,
    input  rec_rd_data,
    output rec_ready
  );
endinterface

// File: rtl/difftest_commit_queue.sv
// ---------------------------------------------------------------------------
// difftest_commit_queue
//   Buffers real retirements from the writeback unit and replays them to the
//   difftest bridge one record per accepted handshake. When an ebreak is
//   captured, later commits are dropped. Once the queue has drained,
//   o_finish is raised, and o_good_trap reports whether a0 was zero at the
//   ebreak.
//
//   Parameters:
//     DEPTH    FIFO entries (power of two, >= 2)
//     TIMEOUT  idle cycles before o_hang (only with DIFFTEST_HANG_DETECT_EN)
//
//   Ports:
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     i_wbu_*               retire strobe, bubble flag, skip flag, pc, ins,
//                           rd write info
//     i_a0_zero             a0 == 0 at retire
//     o_wbu_stall           queue full in RUN; the WBU holds its commit
//     rec                   record channel (difftest_commit_queue_if.master)
//     o_finish              program ended and queue empty (sticky)
//     o_good_trap           a0 was zero at ebreak (qualified by o_finish)
//     o_commit_cnt          real commits accepted into the FIFO
//     o_dbg_state           FSM state: 0 RUN, 1 DRAIN, 2 DONE
//     o_hang                sticky idle timeout (DIFFTEST_HANG_DETECT_EN only)
//
//   Optional feature macro: DIFFTEST_HANG_DETECT_EN
// ---------------------------------------------------------------------------
module difftest_commit_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wbu_commit,
  input  logic                    i_wbu_nop,
  input  logic                    i_wbu_skip,
  input  logic [63:0]             i_wbu_pc,
  input  logic [31:0]             i_wbu_ins,
  input  logic                    i_wbu_rd_we,
  input  logic [4:0]              i_wbu_rd_addr,
  input  logic [63:0]             i_wbu_rd_data,
  input  logic                    i_a0_zero,
  output logic                    o_wbu_stall,
  difftest_commit_queue_if.master rec,
  output logic                    o_finish,
  output logic                    o_good_trap,
  output logic [63:0]             o_commit_cnt,
  output logic [1:0]              o_dbg_state
`ifdef DIFFTEST_HANG_DETECT_EN
  ,
  output logic                    o_hang
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic        skip;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
  } rec_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  rec_t             mem [DEPTH];
  rec_t             in_rec;
  rec_t             head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             good_trap_q;
  logic             full;
  logic             enq;
  logic             deq;
  logic             is_ebreak;

  // The stall is raised only in RUN. In DRAIN and DONE, commits are dropped
  // rather than blocked.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign o_wbu_stall = full && (state_q == ST_RUN);
  assign enq         = i_wbu_commit && !i_wbu_nop && !o_wbu_stall &&
                       (state_q == ST_RUN);
  assign deq         = valid_q && rec.rec_ready;
  assign is_ebreak   = (i_wbu_ins == EBREAK);

  // rd_we is stored already qualified, so x0 writes never reach the bridge.
  always_comb begin
    in_rec         = '0;
    in_rec.skip    = i_wbu_skip;
    in_rec.pc      = i_wbu_pc;
    in_rec.ins     = i_wbu_ins;
    in_rec.rd_we   = i_wbu_rd_we && (i_wbu_rd_addr != 5'd0);
    in_rec.rd_addr = i_wbu_rd_addr;
    in_rec.rd_data = i_wbu_rd_data;
  end

  // Next head computation. The output fields are registered, so the next
  // head is computed here. When the entry being written this cycle becomes
  // the head, it comes from the input: the memory write has not landed yet.
  always_comb begin
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    valid_d = (count_d != '0);

    head_d = '0;
    if (count_d != '0) begin
      if (enq && (count_q == CNT_W'(deq))) begin
        head_d = in_rec;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  // Storage has no reset; its contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      mem[wr_ptr_q] <= in_rec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
      o_commit_cnt <= '0;
      good_trap_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      if (enq) begin
        wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
        o_commit_cnt <= o_commit_cnt + 64'd1;
        if (is_ebreak) begin
          good_trap_q <= i_a0_zero;
        end
      end
    end
  end

  // FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (enq && is_ebreak) state_d = ST_DRAIN;
      ST_DRAIN: if (count_q == '0)    state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  assign rec.rec_valid   = valid_q;
  assign rec.rec_skip    = head_q.skip;
  assign rec.rec_pc      = head_q.pc;
  assign rec.rec_ins     = head_q.ins;
  assign rec.rec_rd_we   = head_q.rd_we;
  assign rec.rec_rd_addr = head_q.rd_addr;
  assign rec.rec_rd_data = head_q.rd_data;

  assign o_finish    = (state_q == ST_DONE);
  assign o_good_trap = good_trap_q && o_finish;
  assign o_dbg_state = state_q;

`ifdef DIFFTEST_HANG_DETECT_EN
  localparam int unsigned HANG_W = $clog2(TIMEOUT + 1);

  logic [HANG_W-1:0] idle_q, idle_d;
  logic              hang_q;

  // Idle counter. It clears on every real commit and counts only in RUN.
  // It saturates at TIMEOUT. o_hang rises on the same edge the counter
  // reaches TIMEOUT.
  always_comb begin
    idle_d = idle_q;
    if (enq) begin
      idle_d = '0;
    end else if ((state_q == ST_RUN) && (idle_q != HANG_W'(TIMEOUT))) begin
      idle_d = idle_q + HANG_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_q <= '0;
      hang_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      if (idle_d == HANG_W'(TIMEOUT)) begin
        hang_q <= 1'b1;
      end
    end
  end

  assign o_hang = hang_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_difftest_commit_queue.sv
module tb_difftest_commit_queue;

  localparam int REC_W = 167;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wbu_commit = 1'b0;
  logic        wbu_nop = 1'b0;
  logic        wbu_skip = 1'b0;
  logic [63:0] wbu_pc = '0;
  logic [31:0] wbu_ins = '0;
  logic        wbu_rd_we = 1'b0;
  logic [4:0]  wbu_rd_addr = '0;
  logic [63:0] wbu_rd_data = '0;
  logic        a0_zero = 1'b0;
  logic        wbu_stall;
  logic        finish;
  logic        good_trap;
  logic [63:0] commit_cnt;
  logic [1:0]  dbg_state;
`ifdef DIFFTEST_HANG_DETECT_EN
  logic        hang;
`endif

  difftest_commit_queue_if rec_if ();

  difftest_commit_queue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wbu_commit  (wbu_commit),
    .i_wbu_nop     (wbu_nop),
    .i_wbu_skip    (wbu_skip),
    .i_wbu_pc      (wbu_pc),
    .i_wbu_ins     (wbu_ins),
    .i_wbu_rd_we   (wbu_rd_we),
    .i_wbu_rd_addr (wbu_rd_addr),
    .i_wbu_rd_data (wbu_rd_data),
    .i_a0_zero     (a0_zero),
    .o_wbu_stall   (wbu_stall),
    .rec           (rec_if),
    .o_finish      (finish),
    .o_good_trap   (good_trap),
    .o_commit_cnt  (commit_cnt),
    .o_dbg_state   (dbg_state)
`ifdef DIFFTEST_HANG_DETECT_EN
    ,
    .o_hang        (hang)
`endif
  );

  // scoreboard
  logic [REC_W-1:0] exp_q[$];
  logic [63:0]      exp_cnt = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted record must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rec_if.rec_valid && rec_if.rec_ready) begin
      if (exp_q.size() == 0) begin
        check("rec_unexpected", {191'd0, rec_if.rec_valid}, 192'd0);
      end else begin
        check("rec_fields",
              {25'd0, rec_if.rec_skip, rec_if.rec_pc, rec_if.rec_ins,
               rec_if.rec_rd_we, rec_if.rec_rd_addr, rec_if.rec_rd_data},
              {25'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: called at posedge+1, returns at posedge+1 after the commit edge
  task automatic drive_commit(input logic skip, input logic [63:0] pc,
                              input logic [31:0] ins, input logic rd_we,
                              input logic [4:0] rd_addr, input logic [63:0] rd_data,
                              input logic nop, input logic a0z, input logic expect_enq);
    wbu_commit  = 1'b1;
    wbu_nop     = nop;
    wbu_skip    = skip;
    wbu_pc      = pc;
    wbu_ins     = ins;
    wbu_rd_we   = rd_we;
    wbu_rd_addr = rd_addr;
    wbu_rd_data = rd_data;
    a0_zero     = a0z;
    if (expect_enq) begin
      exp_q.push_back({skip, pc, ins, rd_we && (rd_addr != 5'd0), rd_addr, rd_data});
      exp_cnt = exp_cnt + 64'd1;
    end
    @(posedge clk); #1;
    wbu_commit = 1'b0;
    wbu_nop    = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while (rec_if.rec_valid && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, {191'd0, rec_if.rec_valid}, 192'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] first_pc;
  logic [63:0] rnd;

  initial begin
    rec_if.rec_ready = 1'b0;
    step(2);
    // reset state
    check("rst_valid", {191'd0, rec_if.rec_valid}, 192'd0);
    check("rst_stall", {191'd0, wbu_stall}, 192'd0);
    check("rst_finish", {191'd0, finish}, 192'd0);
    check("rst_cnt", {128'd0, commit_cnt}, 192'd0);
    rst_n = 1'b1;
    step(1);

    // reset mid-stream with two records queued
    drive_commit(0, 64'h8000_0100, 32'h0000_0013, 1, 5'd3, 64'h11, 0, 0, 1);
    drive_commit(1, 64'h8000_0104, 32'h0000_0013, 1, 5'd4, 64'h22, 0, 0, 1);
    check("pre_rst_valid", {191'd0, rec_if.rec_valid}, 192'd1);
    check("pre_rst_cnt", {128'd0, commit_cnt}, {128'd0, exp_cnt});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {191'd0, rec_if.rec_valid}, 192'd0);
    check("async_rst_pc", {128'd0, rec_if.rec_pc}, 192'd0);
    check("async_rst_cnt", {128'd0, commit_cnt}, 192'd0);
    check("async_rst_skip", {191'd0, rec_if.rec_skip}, 192'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // single commit with the bridge ready
    rec_if.rec_ready = 1'b1;
    drive_commit(0, 64'h8000_0000, 32'h0000_0013, 1, 5'd5, 64'h1234, 0, 0, 1);
    check("single_valid", {191'd0, rec_if.rec_valid}, 192'd1);
    check("single_pc", {128'd0, rec_if.rec_pc}, {128'd0, 64'h8000_0000});
    check("single_rd_data", {128'd0, rec_if.rec_rd_data}, {128'd0, 64'h1234});
    check("single_rd_we", {191'd0, rec_if.rec_rd_we}, 192'd1);
    step(1);
    check("single_valid_off", {191'd0, rec_if.rec_valid}, 192'd0);
    check("single_cnt", {128'd0, commit_cnt}, 192'd1);

    // nop filtered, x0 write demoted
    drive_commit(0, 64'h8000_0004, 32'h0000_0013, 1, 5'd6, 64'h99, 1, 0, 0);
    check("nop_valid", {191'd0, rec_if.rec_valid}, 192'd0);
    check("nop_cnt", {128'd0, commit_cnt}, {128'd0, exp_cnt});
    drive_commit(0, 64'h8000_0008, 32'h0000_0093, 1, 5'd0, 64'h55, 0, 0, 1);
    check("x0_valid", {191'd0, rec_if.rec_valid}, 192'd1);
    check("x0_rd_we", {191'd0, rec_if.rec_rd_we}, 192'd0);
    step(1);

    // back-pressure: fill the queue, then one more commit held by stall
    rec_if.rec_ready = 1'b0;
    first_pc = 64'h8000_1000;
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom(), $urandom()};
      drive_commit(logic'(i % 2), first_pc + 64'(4 * i), 32'h0000_0013 + 32'(i << 7),
                   1, 5'($urandom_range(1, 31)), rnd, 0, 0, 1);
      if (i == 2) check("bp_stall_early", {191'd0, wbu_stall}, 192'd0);
    end
    check("bp_stall_full", {191'd0, wbu_stall}, 192'd1);
    check("bp_cnt", {128'd0, commit_cnt}, {128'd0, exp_cnt});
    wbu_commit = 1'b1; wbu_nop = 1'b0; wbu_skip = 1'b1;
    wbu_pc = 64'h8000_2000; wbu_ins = 32'h0000_0213; wbu_rd_we = 1'b1;
    wbu_rd_addr = 5'd9; wbu_rd_data = 64'hdead_beef;
    exp_q.push_back({1'b1, 64'h8000_2000, 32'h0000_0213, 1'b1, 5'd9, 64'hdead_beef});
    exp_cnt = exp_cnt + 64'd1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("bp_hold_stall", {191'd0, wbu_stall}, 192'd1);
      check("bp_hold_pc", {128'd0, rec_if.rec_pc}, {128'd0, first_pc});
    end
    check("bp_cnt_held", {128'd0, commit_cnt}, {128'd0, exp_cnt - 64'd1});
    rec_if.rec_ready = 1'b1;
    begin
      int g = 0;
      while (wbu_stall && g < 10) begin
        step(1);
        g++;
      end
    end
    check("bp_stall_release", {191'd0, wbu_stall}, 192'd0);
    step(1);
    wbu_commit = 1'b0;
    wait_drain("bp_drain");
    check("bp_cnt_final", {128'd0, commit_cnt}, {128'd0, exp_cnt});
    check("bp_queue_empty", 192'(exp_q.size()), 192'd0);

    // ebreak with records queued
    rec_if.rec_ready = 1'b0;
    drive_commit(0, 64'h8000_3000, 32'h0000_0013, 1, 5'd1, 64'h1, 0, 0, 1);
    drive_commit(1, 64'h8000_3004, 32'h0000_0013, 1, 5'd2, 64'h2, 0, 0, 1);
    drive_commit(0, 64'h8000_3008, 32'h0010_0073, 0, 5'd0, 64'h0, 0, 1, 1);
    check("ebreak_state", {190'd0, dbg_state}, 192'd1);
    drive_commit(0, 64'h8000_300c, 32'h0000_0013, 1, 5'd7, 64'h7, 0, 0, 0);
    check("drain_stall", {191'd0, wbu_stall}, 192'd0);
    check("drain_cnt", {128'd0, commit_cnt}, {128'd0, exp_cnt});
    check("drain_finish", {191'd0, finish}, 192'd0);
    rec_if.rec_ready = 1'b1;
    wait_drain("fin_drain");
    check("fin_not_yet", {191'd0, finish}, 192'd0);
    step(1);
    check("fin_finish", {191'd0, finish}, 192'd1);
    check("fin_good_trap", {191'd0, good_trap}, 192'd1);
    drive_commit(0, 64'h8000_4000, 32'h0000_0013, 1, 5'd8, 64'h8, 0, 0, 0);
    check("done_cnt", {128'd0, commit_cnt}, {128'd0, exp_cnt});
    check("done_valid", {191'd0, rec_if.rec_valid}, 192'd0);
    check("done_finish", {191'd0, finish}, 192'd1);

`ifdef DIFFTEST_HANG_DETECT_EN
    rst_n = 1'b0;
    exp_cnt = '0;
    step(1);
    rst_n = 1'b1;
    step(15);
    check("hang_early", {191'd0, hang}, 192'd0);
    step(1);
    check("hang_set", {191'd0, hang}, 192'd1);
    drive_commit(0, 64'h8000_5000, 32'h0000_0013, 1, 5'd3, 64'h3, 0, 0, 1);
    check("hang_sticky", {191'd0, hang}, 192'd1);
`endif

    step(3);
    check("final_queue_empty", 192'(exp_q.size()), 192'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_commit_queue.md
Name: difftest_commit_queue

Overview:
- Sits between the writeback unit (WBU) and the DPI difftest bridge.
- Captures each real retirement (commit and not nop) into a small FIFO, together with its skip flag, PC, instruction, rd write and a0-zero status.
- Replays records to the bridge one per accepted handshake, so commit bursts and bridge back-pressure do not lose events.
- Detects program end (ebreak) and drains the FIFO before declaring finish.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT, 4096, cycles without a real commit before hang is flagged (optional feature only).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wbu_commit  in  1  WBU retire strobe
- i_wbu_nop  in  1  retiring slot is a bubble
- i_wbu_skip  in  1  device access, interrupt or CLINT access; ref model must skip this record
- i_wbu_pc  in  64  retiring PC
- i_wbu_ins  in  32  retiring instruction
- i_wbu_rd_we  in  1  rd written
- i_wbu_rd_addr  in  5  rd index
- i_wbu_rd_data  in  64  rd value
- i_a0_zero  in  1  a0 == 0 at retire
- o_wbu_stall  out  1  queue full; WBU must hold its commit
- o_rec_valid  out  1  record available
- i_rec_ready  in  1  bridge accepts record
- o_rec_skip  out  1  record skip flag
- o_rec_pc  out  64  record PC
- o_rec_ins  out  32  record instruction
- o_rec_rd_we  out  1  record rd write enable (forced 0 when rd_addr == 0)
- o_rec_rd_addr  out  5  record rd index
- o_rec_rd_data  out  64  record rd value
- o_finish  out  1  program ended, queue empty (sticky)
- o_good_trap  out  1  a0 was zero at ebreak (valid with o_finish)
- o_commit_cnt  out  64  count of real commits accepted into the FIFO

Behaviour:
- Reset (async, i_rst_n low):
  - Pointers, count, state and o_commit_cnt go to 0.
  - All outputs go to 0.
  - FIFO contents are don't-care.
- Enqueue condition: real_commit = i_wbu_commit & ~i_wbu_nop & ~o_wbu_stall & state == RUN.
  - One record is written per enqueue.
  - o_commit_cnt increments by 1 and wraps modulo 2^64.
- Dequeue condition: o_rec_valid & i_rec_ready.
  - Records leave in FIFO order, one per cycle max.
- Outputs are registered from the head entry; o_rec_valid = (count != 0).
  - Latency from enqueue to o_rec_valid is 1 cycle when the FIFO is empty (no bypass).
  - While valid and not ready, all o_rec_* fields hold stable.
- o_wbu_stall = (count == DEPTH).
  - Simultaneous enqueue and dequeue when full is not allowed: stall wins.
  - Simultaneous enqueue and dequeue when not full leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- State machine:
  - RUN: enqueuing a record with ins == 32'h0010_0073 (ebreak) latches i_a0_zero into o_good_trap and moves to DRAIN. The ebreak record itself is enqueued. Further commits are ignored (not enqueued, not counted).
  - DRAIN: when count == 0, move to DONE.
  - DONE: o_finish = 1. Terminal until reset.
- Reset mid-drain: everything returns to RUN with an empty queue and o_finish = 0.
- o_wbu_stall is 0 in DRAIN and DONE; the WBU is not blocked, its commits are simply dropped.

Optional Feature:
- Macro DIFFTEST_HANG_DETECT_EN.
- With the macro:
  - Adds output o_hang (1 bit).
  - Adds an internal cycle counter, cleared on reset and on every real_commit, incremented otherwise in RUN. It saturates at TIMEOUT.
  - When it reaches TIMEOUT, o_hang is set sticky until reset.
  - o_hang does not affect the queue.
- Without the macro:
  - The port and counter do not exist.
  - TIMEOUT is unused.

Test Plan:
- Reset mid-stream: while 2 records are queued, assert i_rst_n low asynchronously → all outputs 0 immediately; after release, commit works from an empty queue.
- Single commit, bridge ready: PC 0x8000_0000, ins 0x0000_0013, rd x5 = 0x1234 → o_rec_valid next cycle with matching fields, then 0; o_commit_cnt = 1.
- Nop and x0 filtering: commit with nop = 1 → no record, count unchanged. Commit writing rd = 0 → record with o_rec_rd_we = 0.
- Back-pressure: hold i_rec_ready = 0 and issue 5 commits, DEPTH = 4 → o_wbu_stall high after the 4th. The 5th is enqueued once ready is raised. Records emerge in order with the skip flags preserved.
- Finish: ebreak with a0_zero = 1 while 2 records are queued → no further enqueues; o_finish = 1 and o_good_trap = 1 one cycle after the last record drains.
- Hang (with DIFFTEST_HANG_DETECT_EN, TIMEOUT = 16): no commits for 16 cycles → o_hang = 1; a later commit does not clear it.
